// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, prefetch entry type and a constant log2 helper
package fetch_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP = '0;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/fetch_stage_buffered_if.sv
// fetch_stage_buffered_if: instruction-memory port plus the IF/ID outputs of the fetch stage
interface fetch_stage_buffered_if;
    import fetch_pkg::*;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;
    logic            id_valid;
    logic [XLEN-1:0] id_pc;
    logic [XLEN-1:0] id_next_pc;
    logic [XLEN-1:0] id_instr;

    modport master (
        output imem_req, imem_addr, id_valid, id_pc, id_next_pc, id_instr,
        input  imem_gnt, imem_rvalid, imem_rdata
    );
    modport slave (
        input  imem_req, imem_addr, id_valid, id_pc, id_next_pc, id_instr,
        output imem_gnt, imem_rvalid, imem_rdata
    );
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous prefetch FIFO with clear; pointers carry one extra wrap bit for full/empty
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    localparam int AW = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             clear_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [AW:0]      count_o,
    output logic             full_o,
    output logic             empty_o
);
    logic [AW:0]      wr_q, rd_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign count_o = wr_q - rd_q;
    assign empty_o = wr_q == rd_q;
    assign full_o  = count_o == (AW+1)'(DEPTH);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign rdata_o = mem_q[rd_q[AW-1:0]];

    // pointer update; clear discards everything, including a same-cycle push
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else if (clear_i) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_q + (AW+1)'(do_push);
            rd_q <= rd_q + (AW+1)'(do_pop);
        end
    end

    // storage write; contents need no reset since empty/full gate every read
    always_ff @(posedge clk) begin
        if (do_push && !clear_i) mem_q[wr_q[AW-1:0]] <= wdata_i;
    end
endmodule

// File: rtl/fetch_stage_buffered.sv
// fetch_stage_buffered: PC, imem request issue, prefetch buffering and the IF/ID register
module fetch_stage_buffered
    import fetch_pkg::*;
#(
    parameter int              FIFO_DEPTH      = 4,
    parameter int              MAX_OUTSTANDING = 2,
    parameter int              INSTR_BYTES     = 4,
    parameter logic [XLEN-1:0] RESET_PC        = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pc_write,
    input  logic            pc_src,
    input  logic [XLEN-1:0] branch_addr,
    input  logic            flush,
    input  logic            freeze,
    fetch_stage_buffered_if.master bus
);
    localparam int AW = clog2(FIFO_DEPTH);
    localparam int OW = clog2(MAX_OUTSTANDING + 1);
    localparam int QW = MAX_OUTSTANDING > 1 ? clog2(MAX_OUTSTANDING) : 1;

    logic [XLEN-1:0] pc_q, pc_d;
    logic [OW-1:0]   out_q, out_d, stale_q, stale_d;
    logic [XLEN-1:0] aq_q [MAX_OUTSTANDING];
    logic [QW-1:0]   qwr_q, qrd_q;
    logic            id_valid_q;
    logic [XLEN-1:0] id_pc_q, id_next_pc_q, id_instr_q;
    logic            accept, resp, push, load;
    logic [AW:0]     fifo_count;
    logic            fifo_full, fifo_empty;
    fetch_entry_t    head;

    function automatic logic [QW-1:0] nxt(input logic [QW-1:0] p);
        return (p == QW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    // Reserving FIFO room for every in-flight request keeps the FIFO from ever overflowing.
    assign bus.imem_req  = pc_write && !pc_src && !fifo_full && (out_q < OW'(MAX_OUTSTANDING))
                           && (int'(fifo_count) + int'(out_q) < FIFO_DEPTH);
    assign bus.imem_addr = pc_q;
    assign accept        = bus.imem_req && bus.imem_gnt;
    assign resp          = bus.imem_rvalid && (out_q != '0);
    assign push          = resp && !pc_src && (stale_q == '0);
    assign load          = !flush && !freeze;

    assign bus.id_valid   = id_valid_q;
    assign bus.id_pc      = id_pc_q;
    assign bus.id_next_pc = id_next_pc_q;
    assign bus.id_instr   = id_instr_q;

    // next PC and counters; a redirect marks everything still in flight as stale
    always_comb begin
        pc_d    = pc_src ? branch_addr : accept ? pc_q + XLEN'(INSTR_BYTES) : pc_q;
        out_d   = out_q + OW'(accept) - OW'(resp);
        stale_d = pc_src ? out_d : (resp && stale_q != '0) ? stale_q - 1'b1 : stale_q;
    end

    // PC, in-flight bookkeeping and request-address queue pointers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q    <= RESET_PC;
            out_q   <= '0;
            stale_q <= '0;
            qwr_q   <= '0;
            qrd_q   <= '0;
        end else begin
            pc_q    <= pc_d;
            out_q   <= out_d;
            stale_q <= stale_d;
            if (accept) qwr_q <= nxt(qwr_q);
            if (resp) qrd_q <= nxt(qrd_q);
        end
    end

    // remember each accepted address so its response can be tagged in order
    always_ff @(posedge clk) begin
        if (accept) aq_q[qwr_q] <= pc_q;
    end

    fetch_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst),
        .push_i  (push),
        .pop_i   (load),
        .clear_i (pc_src),
        .wdata_i ({aq_q[qrd_q], bus.imem_rdata}),
        .rdata_o (head),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // IF/ID register: flush beats freeze beats load; an empty FIFO loads a bubble
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            id_valid_q   <= 1'b0;
            id_pc_q      <= '0;
            id_next_pc_q <= '0;
            id_instr_q   <= NOP;
        end else if (flush) begin
            id_valid_q <= 1'b0;
            id_instr_q <= NOP;
        end else if (!freeze) begin
            id_valid_q <= !fifo_empty;
            id_instr_q <= fifo_empty ? NOP : head.instr;
            if (!fifo_empty) begin
                id_pc_q      <= head.pc;
                id_next_pc_q <= head.pc + XLEN'(INSTR_BYTES);
            end
        end
    end
endmodule
